divu_hilo_unit: RTL and testbench

Multi-cycle unsigned divider with its own Hi/Lo register pair. It answers the DIVU / MFHI / MFLO control codes that the ALU bench drives over the shared `Signal` / `dataA` / `dataB` / `Output` interface. It sits beside the single-cycle ALU datapath inside the ALU top level:
- DIVU starts a 32-iteration restoring division.
- The remainder goes to Hi and the quotient goes to Lo.
- Later MFHI/MFLO codes read the pair back through a registered output.

---
 rtl/divu_hilo_unit.sv | 139 +++++++++++++
 tb/tb_divu_hilo_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/divu_hilo_unit.sv
// divu_hilo_unit: multi-cycle unsigned restoring divider with a private Hi/Lo pair.
//   DIVU starts a WIDTH-iteration division (remainder -> Hi, quotient -> Lo).
//   MFHI/MFLO copy Hi/Lo onto the registered Output; other codes are ignored.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   dataA  - dividend, sampled with DIVU
//   dataB  - divisor, sampled with DIVU
//   Signal - operation code
//   Output - registered Hi/Lo readback
//   busy   - division in progress
//   done   - one-cycle pulse after Hi/Lo are written
module divu_hilo_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [5:0]  DIVU_CODE = 6'd27,
  parameter logic [5:0]  MFHI_CODE = 6'd16,
  parameter logic [5:0]  MFLO_CODE = 6'd18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One restoring step; compare is WIDTH+1 bits so the shifted-out MSB is kept.
  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  always_comb begin
    t      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    ge     = t >= {1'b0, div_q};
    r_step = ge ? (t - {1'b0, div_q}) : t;
    q_step = {q_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Signal == DIVU_CODE) begin
          div_d   = dataB;
          q_d     = dataA;
          r_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastIter) begin
          hi_d    = r_step[WIDTH-1:0];
          lo_d    = q_step;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Readback uses the current Hi/Lo, so a read on the write edge sees old data.
  always_comb begin
    out_d = out_q;
    if (Signal == MFHI_CODE) begin
      out_d = hi_q;
    end else if (Signal == MFLO_CODE) begin
      out_d = lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Output = out_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_divu_hilo_unit.sv
module tb_divu_hilo_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic [31:0] Output;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  divu_hilo_unit dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .Output (Output),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic; divide by zero gives Hi=a, Lo=all ones.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
    if (b == 0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endtask

  task automatic rd(input logic [5:0] code, input logic [31:0] exp, input string tag);
    Signal = code;
    step();
    Signal = 6'd0;
    chk(tag, Output, exp);
  endtask

  // Issue DIVU and follow it to completion, checking busy length and done pulse.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    Signal = 6'd27;
    dataA  = a;
    dataB  = b;
    step();
    Signal = 6'd0;
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_busy_len"}, n, 32'd32);
    chk({tag, "_done_hi"}, {31'd0, done}, 32'd1);
    step();
    chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
  endtask

  task automatic check_pair(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] hi, lo;
    ref_div(a, b, hi, lo);
    step();
    step();
    rd(6'd16, hi, {tag, "_hi"});
    rd(6'd18, lo, {tag, "_lo"});
  endtask

  initial begin
    int n;
    int pulses;
    logic [31:0] a, b, keep;

    // Reset state
    #12;
    chk("rst_output", Output, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Overlapping DIVU ignored; read during RUN sees pre-division Hi (0)
    Signal = 6'd27; dataA = 32'd100; dataB = 32'd7;
    step();
    Signal = 6'd0;
    repeat (9) step();
    Signal = 6'd27; dataA = 32'd9; dataB = 32'd3;
    step();
    Signal = 6'd0;
    repeat (9) step();
    rd(6'd16, 32'd0, "run_read_old_hi");
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("overlap_busy_end", n, 32'd12);
    chk("overlap_done", {31'd0, done}, 32'd1);
    // DIVU during DONE must be ignored
    Signal = 6'd27; dataA = 32'd9; dataB = 32'd3;
    step();
    Signal = 6'd0;
    chk("done_divu_ignored", {31'd0, busy}, 32'd0);
    check_pair(32'd100, 32'd7, "overlap");

    // Directed boundaries
    run_div(32'd100, 32'd7, "d100_7");
    check_pair(32'd100, 32'd7, "d100_7");
    run_div(32'hFFFF_FFFF, 32'd1, "dmax_1");
    check_pair(32'hFFFF_FFFF, 32'd1, "dmax_1");
    run_div(32'd6, 32'hFFFF_FFFF, "d6_max");
    check_pair(32'd6, 32'hFFFF_FFFF, "d6_max");
    run_div(32'd5, 32'd0, "d5_0");
    check_pair(32'd5, 32'd0, "d5_0");
    chk("d5_0_const_lo", Output, 32'hFFFF_FFFF);

    // Other codes leave Output and Hi/Lo alone
    keep = Output;
    Signal = 6'd32;
    step();
    chk("add_output", Output, keep);
    chk("add_busy", {31'd0, busy}, 32'd0);
    Signal = 6'd36;
    step();
    Signal = 6'd0;
    chk("and_output", Output, keep);
    chk("and_busy", {31'd0, busy}, 32'd0);
    rd(6'd16, 32'd5, "other_hi_kept");

    // Reset mid-division
    Signal = 6'd27; dataA = 32'd1000; dataB = 32'd3;
    step();
    Signal = 6'd0;
    repeat (14) step();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_output", Output, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      step();
      if (done) pulses++;
    end
    chk("midrst_no_done", pulses, 32'd0);
    rd(6'd16, 32'd0, "midrst_hi");
    rd(6'd18, 32'd0, "midrst_lo");
    run_div(32'd1000, 32'd3, "d1000_3");
    check_pair(32'd1000, 32'd3, "d1000_3");

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i == 3) b = 32'd0;
      if (i == 6) b = a;
      run_div(a, b, $sformatf("rnd%0d", i));
      check_pair(a, b, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
